seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment drive bus: observes the 12-bit-style {digit select, segment byte} signal and reconstructs the per-cell segment bytes.
- Sits in bench/loopback paths and board-level scanners that read a multiplexed display; publishes a complete frame once every cell has been seen.
- Filters glitches and blank phases; flags illegal selects and a stalled bus.

Parameters:
- NUMCELLS, 4, number of digit cells; select field width.
- STABLE_CYCLES, 8, consecutive identical samples required before a capture (range 1..255).
- TIMEOUT_CYCLES, 65536, clocks without any capture before stale asserts (>= 2).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sig  input  NUMCELLS+8  bus under observation: [NUMCELLS+7:8] one-hot digit select, [7:0] segment byte (bit0=A ... bit7=DP).
- cellvalout  output  8*NUMCELLS  last complete frame; slot k = [8k+7:8k].
- frame_valid  output  1  one-cycle pulse when cellvalout updates.
- cell_seen  output  NUMCELLS  cells captured in the frame in progress.
- err_multi  output  1  one-cycle pulse: stable select with more than one bit set.
- stale  output  1  no capture for TIMEOUT_CYCLES; sticky until next frame_valid.

Behaviour:
- Input path: sig passes through two flops (sig_s = second stage); all logic uses sig_s. sig_s and its previous value reset to 0.
- Stability: stable_cnt clears to 0 when sig_s differs from its previous value, otherwise saturating increment to STABLE_CYCLES. armed sets on any change and clears on a capture or err_multi event, so each stable period produces at most one event.
- Event on edge where stable_cnt reaches STABLE_CYCLES-1 (i.e. STABLE_CYCLES equal samples) and armed=1:
  - select == 0 (blank phase): no action, no error; armed clears.
  - select one-hot, bit k: shadow slot k <= segment byte, cell_seen[k] <= 1, timeout counter clears.
  - select multi-hot: err_multi pulses next cycle, shadow and cell_seen unchanged.
- States: IDLE (after reset, cell_seen=0), COLLECT (>=1 cell seen), PUBLISH (single cycle). IDLE->COLLECT on first capture; COLLECT->PUBLISH when the capture makes cell_seen all ones; PUBLISH->IDLE unconditionally.
- PUBLISH: cellvalout <= shadow (including the byte captured on the completing edge); frame_valid=1 for exactly that cycle; cell_seen clears to 0; stale clears. A capture arriving during PUBLISH counts toward the next frame.
- Recapture of an already-seen cell before frame completion: shadow overwritten (latest wins), no error, no frame.
- Latency: constant stable value applied at sig -> shadow written on clock 2+STABLE_CYCLES after it first appears; frame_valid on the following clock.
- Timeout: 17-bit (clog2) counter counts when no capture; at TIMEOUT_CYCLES stale <= 1 and counter holds. cell_seen is preserved.
- Reset (any time, including mid-frame): cellvalout=0, frame_valid=0, cell_seen=0, err_multi=0, stale=0, shadow=0, stable_cnt=0, armed=0, timeout counter=0, state IDLE.
- Width rules: select index uses NUMCELLS bits; one-hot test is popcount==1; no arithmetic wraps except the timeout counter, which saturates.

Decomposition:
- Shared package seven_seg_pkg: state enum (IDLE, COLLECT, PUBLISH), SEG_W=8, segment bit index constants (SEG_A..SEG_DP).
- One sub-module: seven_seg_stable, containing the 2-flop input path, stable_cnt and armed, and producing a single-cycle event strobe plus the stable value. The parent holds the FSM, shadow, timeout and outputs.

Test Plan:
- Reset then hold sig=0x000 for 100 clocks (STABLE_CYCLES=8) -> no frame_valid, cell_seen=0, err_multi never pulses.
- Drive sel=1000/0x3F, 0100/0x06, 0010/0x5B, 0001/0x4F, each for 20 clocks, separated by 5-clock blanks -> single frame_valid pulse, cellvalout=0x3F065B4F, cell_seen returns to 0.
- 1-clock glitch sel=0100/0xFF inside a stable 0100/0x06 period -> slot 2 stays 0x06, no extra capture.
- Stable sel=0110/0x7F for 20 clocks -> exactly one err_multi pulse; shadow and cell_seen unchanged.
- Capture slots 3,2,1, then assert reset for one clock, then a full frame of 0x11,0x22,0x33,0x44 -> cellvalout=0x11223344 with no residue from before reset.
- TIMEOUT_CYCLES=64: capture one cell, then hold blank -> stale rises 64 clocks after the capture, cell_seen unchanged; completing the frame -> frame_valid and stale=0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment capture block.
// Segment byte layout is A in bit 0 through DP in bit 7.
package seven_seg_pkg;

  localparam int SEG_W  = 8;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH
  } state_t;

endpackage

// File: rtl/seven_seg_stable.sv
// Synchronises the observed bus and emits one event strobe per
// stable period of STABLE_CYCLES identical samples.
module seven_seg_stable
  import seven_seg_pkg::*;
#(
  parameter int W             = SEG_W + 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] sig,
  output logic         evt,
  output logic [W-1:0] value
);

  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CHIT = 8'(STABLE_CYCLES - 1);

  logic [W-1:0] sig_m;
  logic [W-1:0] sig_s;
  logic [W-1:0] sig_p;
  logic [7:0]   cnt;
  logic [7:0]   cnt_next;
  logic         armed;
  logic         changed;

  assign changed = sig_s != sig_p;
  assign value   = sig_s;

  always_comb begin
    cnt_next = cnt;
    if (changed)
      cnt_next = '0;
    else if (cnt < CMAX)
      cnt_next = cnt + 8'd1;
  end

  // A change arms in the same cycle so STABLE_CYCLES=1 still fires.
  assign evt = (armed || changed) && (cnt_next == CHIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      sig_m <= '0;
      sig_s <= '0;
      sig_p <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      sig_m <= sig;
      sig_s <= sig_m;
      sig_p <= sig_s;
      cnt   <= cnt_next;
      if (evt)
        armed <= 1'b0;
      else if (changed)
        armed <= 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Reconstructs per-cell segment bytes from a multiplexed display bus
// and publishes a frame once every cell has been captured.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUMCELLS       = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUMCELLS+7:0]       sig,
  output logic [SEG_W*NUMCELLS-1:0] cellvalout,
  output logic                      frame_valid,
  output logic [NUMCELLS-1:0]       cell_seen,
  output logic                      err_multi,
  output logic                      stale
);

  localparam int W  = NUMCELLS + SEG_W;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic                      evt;
  logic [W-1:0]              value;
  logic [NUMCELLS-1:0]       sel;
  logic [SEG_W-1:0]          seg;
  logic                      capture;
  logic                      multi;
  logic                      complete;
  logic [NUMCELLS-1:0]       seen_next;
  logic [SEG_W*NUMCELLS-1:0] shadow;
  logic [SEG_W*NUMCELLS-1:0] shadow_next;
  logic [TW-1:0]             tcnt;
  logic [TW-1:0]             tcnt_next;
  state_t                    state;
  state_t                    state_next;

  seven_seg_stable #(
    .W            (W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .clock(clock),
    .reset(reset),
    .sig  (sig),
    .evt  (evt),
    .value(value)
  );

  assign sel       = value[W-1:SEG_W];
  assign seg       = value[SEG_DP:SEG_A];
  assign capture   = evt && ($countones(sel) == 1);
  assign multi     = evt && ($countones(sel) > 1);
  assign seen_next = cell_seen | sel;
  assign complete  = capture && (state != PUBLISH)
                     && (seen_next == '1);

  assign frame_valid = (state == PUBLISH);

  always_comb begin
    shadow_next = shadow;
    for (int k = 0; k < NUMCELLS; k++)
      if (capture && sel[k])
        shadow_next[SEG_W*k +: SEG_W] = seg;
  end

  always_comb begin
    tcnt_next = tcnt;
    if (capture)
      tcnt_next = '0;
    else if (tcnt < TMAX)
      tcnt_next = tcnt + TW'(1);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (complete) state_next = PUBLISH;
               else if (capture) state_next = COLLECT;
      COLLECT: if (complete) state_next = PUBLISH;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      cellvalout <= '0;
      cell_seen  <= '0;
      err_multi  <= 1'b0;
      tcnt       <= '0;
      stale      <= 1'b0;
    end else begin
      shadow    <= shadow_next;
      err_multi <= multi;
      tcnt      <= tcnt_next;
      // Completing capture is folded into the published frame.
      if (complete) begin
        cellvalout <= shadow_next;
        cell_seen  <= '0;
        stale      <= 1'b0;
      end else begin
        if (capture)
          cell_seen <= seen_next;
        if (tcnt_next == TMAX)
          stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench: stimulus tables, corner sequences and random
// bus activity checked against a run-length reference model.
module tb_seven_seg_capture;

  localparam int N = 4;
  localparam int S = 8;
  localparam int T = 64;
  localparam int W = N + 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   sig   = '0;
  logic [8*N-1:0] cellvalout;
  logic           frame_valid;
  logic [N-1:0]   cell_seen;
  logic           err_multi;
  logic           stale;

  always #5 clock = ~clock;

  seven_seg_capture #(
    .NUMCELLS      (N),
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sig        (sig),
    .cellvalout (cellvalout),
    .frame_valid(frame_valid),
    .cell_seen  (cell_seen),
    .err_multi  (err_multi),
    .stale      (stale)
  );

  int checks = 0;
  int errors = 0;
  int frames_dut = 0;
  int errs_dut = 0;

  logic [W-1:0]   hist[$];
  logic [7:0]     m_shadow[N];
  logic [N-1:0]   m_seen;
  logic [8*N-1:0] m_out;
  logic           m_pub;
  logic           m_err;
  logic           m_stale;
  int             m_tmo;

  typedef struct {
    logic [W-1:0]   sig;
    int             hold;
    logic [N-1:0]   exp_seen;
    logic [8*N-1:0] exp_out;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (S + 3) hist.push_back('0);
    foreach (m_shadow[k]) m_shadow[k] = 8'h00;
    m_seen  = '0;
    m_out   = '0;
    m_pub   = 1'b0;
    m_err   = 1'b0;
    m_stale = 1'b0;
    m_tmo   = 0;
  endtask

  // A cell is taken when the bus value seen two clocks ago ends a run
  // of exactly S equal samples that began with a change.
  task automatic model_edge();
    int           n;
    logic [W-1:0] v;
    logic         run_ok;
    logic         ev;
    logic         cap;
    logic [N-1:0] s;
    int           pc;
    if (reset) begin
      model_reset();
      return;
    end
    hist.push_back(sig);
    if (hist.size() > S + 3) void'(hist.pop_front());
    n = hist.size();
    v = hist[n-3];
    run_ok = 1'b1;
    for (int i = 0; i < S; i++)
      if (hist[n-3-i] != v) run_ok = 1'b0;
    ev  = run_ok && (hist[n-3-S] != v);
    s   = v[W-1:8];
    pc  = $countones(s);
    cap = ev && (pc == 1);
    m_err = ev && (pc > 1);
    m_pub = 1'b0;
    if (cap) begin
      for (int k = 0; k < N; k++)
        if (s[k]) m_shadow[k] = v[7:0];
      m_seen = m_seen | s;
      m_tmo  = 0;
      if (m_seen == '1) begin
        for (int k = 0; k < N; k++) m_out[8*k +: 8] = m_shadow[k];
        m_seen  = '0;
        m_pub   = 1'b1;
        m_stale = 1'b0;
      end
    end else begin
      if (m_tmo < T) m_tmo++;
      if (m_tmo == T) m_stale = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("cell_seen", cell_seen, m_seen);
    check("cellvalout", cellvalout, m_out);
    check("frame_valid", frame_valid, m_pub);
    check("err_multi", err_multi, m_err);
    check("stale", stale, m_stale);
    if (frame_valid) frames_dut++;
    if (err_multi) errs_dut++;
  endtask

  task automatic run(input logic [W-1:0] v, input int n);
    repeat (n) begin
      sig = v;
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    run('0, 1);
    reset = 1'b0;
  endtask

  initial begin
    int cap_at;
    int rise_at;
    int f0;
    logic [N-1:0] s;
    logic [W-1:0] v;

    tbl[0] = '{12'h000, 100, 4'b0000, 32'h0};
    tbl[1] = '{12'h83F, 20, 4'b1000, 32'h0};
    tbl[2] = '{12'h000, 5, 4'b1000, 32'h0};
    tbl[3] = '{12'h406, 20, 4'b1100, 32'h0};
    tbl[4] = '{12'h000, 5, 4'b1100, 32'h0};
    tbl[5] = '{12'h25B, 20, 4'b1110, 32'h0};
    tbl[6] = '{12'h000, 5, 4'b1110, 32'h0};
    tbl[7] = '{12'h14F, 20, 4'b0000, 32'h3F065B4F};

    model_reset();
    reset = 1'b1;
    run('0, 2);
    check("reset_out", cellvalout, 32'h0);
    reset = 1'b0;

    frames_dut = 0;
    errs_dut   = 0;
    foreach (tbl[i]) begin
      run(tbl[i].sig, tbl[i].hold);
      check("tbl_seen", cell_seen, tbl[i].exp_seen);
      check("tbl_out", cellvalout, tbl[i].exp_out);
    end
    check("tbl_frames", frames_dut, 1);
    check("tbl_errs", errs_dut, 0);

    // Glitch before the period settles must not produce a capture.
    run(12'h406, 4);
    run(12'h4FF, 1);
    run(12'h406, 20);
    check("glitch_seen", cell_seen, 4'b0100);
    run(12'h8AA, 20);
    run(12'h2BB, 20);
    run(12'h1CC, 20);
    check("glitch_out", cellvalout, 32'hAA06BBCC);

    // Multi-hot select between partial captures.
    run(12'h433, 20);
    run(12'h244, 20);
    errs_dut = 0;
    run(12'h67F, 20);
    check("multi_pulses", errs_dut, 1);
    check("multi_seen", cell_seen, 4'b0110);
    run(12'h822, 20);
    run(12'h111, 20);
    check("multi_out", cellvalout, 32'h22334411);

    // Reset mid-frame wipes everything.
    run(12'h8AA, 20);
    run(12'h4BB, 20);
    run(12'h2CC, 20);
    check("pre_reset_seen", cell_seen, 4'b1110);
    pulse_reset();
    check("post_reset_out", cellvalout, 32'h0);
    check("post_reset_seen", cell_seen, 4'b0000);
    run(12'h811, 20);
    run(12'h422, 20);
    run(12'h233, 20);
    run(12'h144, 20);
    check("post_reset_frame", cellvalout, 32'h11223344);

    // Timeout after a single capture, then frame completion.
    pulse_reset();
    cap_at  = -1;
    rise_at = -1;
    for (int i = 0; i < 150; i++) begin
      run((i < 20) ? 12'h111 : 12'h000, 1);
      if (cap_at < 0 && cell_seen != 0) cap_at = i;
      if (rise_at < 0 && stale) rise_at = i;
    end
    check("stale_delay", rise_at - cap_at, 64);
    check("stale_seen", cell_seen, 4'b0001);
    f0 = frames_dut;
    run(12'h822, 20);
    run(12'h433, 20);
    run(12'h244, 20);
    check("stale_frame", frames_dut - f0, 1);
    check("stale_cleared", stale, 1'b0);

    // Random bus activity against the model.
    for (int p = 0; p < 300; p++) begin
      case ($urandom_range(0, 3))
        0:       s = '0;
        1, 2:    s = N'(1 << $urandom_range(0, N - 1));
        default: s = N'($urandom_range(0, 15));
      endcase
      v = {s, 8'($urandom_range(0, 255))};
      run(v, $urandom_range(1, 14));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
